// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU path.
//   FN_*        : MIPS funct codes understood by the sequencer and the slice
//   state_t     : sequencer control states
//   is_legal_fn : 1 when a funct code is one of the five supported operations
package alu_pkg;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_legal_fn(input logic [5:0] ctl);
    return (ctl == FN_ADD) || (ctl == FN_SUB) || (ctl == FN_AND) ||
           (ctl == FN_OR)  || (ctl == FN_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_sequencer_slice.sv
// Combinational 1-bit ALU slice driven by alu_serial_sequencer.
// It sits beside the sequencer in the parent and is wired through slc_*.
//   ctl   : funct code (and/or select the logic result, anything else adds)
//   a, b  : operand bits
//   invb  : invert b (subtract / set-less-than)
//   cin   : carry in
//   sum   : result bit
//   carry : full-adder carry out of (a, b^invb, cin)
module alu_serial_sequencer_slice
  import alu_pkg::*;
(
  input  logic [5:0] ctl,
  input  logic       a,
  input  logic       b,
  input  logic       invb,
  input  logic       cin,
  output logic       sum,
  output logic       carry
);

  logic bb;

  assign bb    = b ^ invb;
  assign carry = (a & bb) | (a & cin) | (bb & cin);

  always_comb begin
    sum = a ^ bb ^ cin;
    case (ctl)
      FN_AND:  sum = a & b;
      FN_OR:   sum = a | b;
      default: sum = a ^ bb ^ cin;
    endcase
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU issuing side. Accepts one op over req_*, drives an external
// 1-bit slice LSB-first for WIDTH cycles while chaining the carry, and returns
// result/zero/overflow/illegal over rsp_*.
//   clk, rst     : clock, synchronous active-high reset
//   req_*        : request port (valid/ready), funct code and operands
//   rsp_*        : response port (valid/ready), result and flags
//   slc_*        : connection to the external bit slice
module alu_serial_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_ctl,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_illegal,
  output logic [5:0]       slc_ctl,
  output logic             slc_a,
  output logic             slc_b,
  output logic             slc_invb,
  output logic             slc_cin,
  input  logic             slc_sum,
  input  logic             slc_carry
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  state_t           state, state_d;
  logic [5:0]       ctl_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             invb_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             c_msb_q;

  logic             last_bit;
  logic [WIDTH-1:0] fin_result;
  logic             fin_ovf;

  assign last_bit = (cnt == LAST);

  // Final values are assembled combinationally from the MSB slice output in
  // the last RUN cycle so the response registers load on the same edge that
  // enters DONE.
  always_comb begin
    logic [WIDTH-1:0] full;
    logic             ovf_raw;
    full             = res_q;
    full[WIDTH-1]    = slc_sum;
    ovf_raw          = c_msb_q ^ slc_carry;
    fin_result       = full;
    fin_ovf          = 1'b0;
    if (ctl_q == FN_SLT) begin
      // Sign of a-b corrected by overflow gives the true signed compare.
      fin_result     = '0;
      fin_result[0]  = slc_sum ^ ovf_raw;
    end else if ((ctl_q == FN_ADD) || (ctl_q == FN_SUB)) begin
      fin_ovf        = ovf_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    slc_ctl   = '0;
    slc_a     = 1'b0;
    slc_b     = 1'b0;
    slc_invb  = 1'b0;
    slc_cin   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        slc_ctl  = ctl_q;
        slc_a    = a_q[cnt];
        slc_b    = b_q[cnt];
        slc_invb = invb_q;
        slc_cin  = (cnt == '0) ? invb_q : carry_q;
        if (last_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      invb_q       <= 1'b0;
      cnt          <= '0;
      carry_q      <= 1'b0;
      c_msb_q      <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            ctl_q       <= req_ctl;
            a_q         <= req_a;
            b_q         <= req_b;
            invb_q      <= (req_ctl == FN_SUB) || (req_ctl == FN_SLT);
            rsp_illegal <= !is_legal_fn(req_ctl);
            cnt         <= '0;
            carry_q     <= 1'b0;
            c_msb_q     <= 1'b0;
          end
        end
        ST_RUN: begin
          res_q[cnt] <= slc_sum;
          carry_q    <= slc_carry;
          if (cnt == PENULT) c_msb_q <= slc_carry;
          if (last_bit) begin
            rsp_result   <= fin_result;
            rsp_zero     <= (fin_result == '0);
            rsp_overflow <= fin_ovf;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
module tb_alu_serial_sequencer;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_ctl;
  logic [WIDTH-1:0] req_a, req_b;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_overflow, rsp_illegal;
  logic [5:0]       slc_ctl;
  logic             slc_a, slc_b, slc_invb, slc_cin, slc_sum, slc_carry;

  alu_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctl(req_ctl),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
    .slc_ctl(slc_ctl), .slc_a(slc_a), .slc_b(slc_b), .slc_invb(slc_invb),
    .slc_cin(slc_cin), .slc_sum(slc_sum), .slc_carry(slc_carry)
  );

  alu_serial_sequencer_slice u_slice (
    .ctl(slc_ctl), .a(slc_a), .b(slc_b), .invb(slc_invb), .cin(slc_cin),
    .sum(slc_sum), .carry(slc_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] ctl, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    case (ctl)
      FN_ADD: begin
        e.result = a + b;
        e.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (e.result[WIDTH-1] != a[WIDTH-1]);
      end
      FN_SUB: begin
        e.result = a - b;
        e.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (e.result[WIDTH-1] != a[WIDTH-1]);
      end
      FN_AND:  e.result = a & b;
      FN_OR:   e.result = a | b;
      FN_SLT:  e.result = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: begin
        e.result = a + b;
        e.ill    = 1'b1;
      end
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Issue one op, wait for the response, check it, optionally stall the
  // consumer for 'hold' cycles, then accept the response.
  task automatic run_op(input string tag, input logic [5:0] ctl,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int hold);
    int   cyc;
    exp_t e;
    @(negedge clk);
    chk({tag, ".req_ready_idle"}, WIDTH'(req_ready), WIDTH'(1));
    req_valid = 1'b1; req_ctl = ctl; req_a = a; req_b = b;
    @(posedge clk); #1;
    sb.push_back(model(ctl, a, b));
    req_valid = 1'b0; req_ctl = '0; req_a = '1; req_b = '1;
    chk({tag, ".req_ready_run"}, WIDTH'(req_ready), WIDTH'(0));
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, WIDTH'(cyc), WIDTH'(WIDTH));
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, WIDTH'(0), WIDTH'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, ".result"}, rsp_result, e.result);
      chk({tag, ".zero"}, WIDTH'(rsp_zero), WIDTH'(e.zero));
      chk({tag, ".ovf"}, WIDTH'(rsp_overflow), WIDTH'(e.ovf));
      chk({tag, ".illegal"}, WIDTH'(rsp_illegal), WIDTH'(e.ill));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, ".hold_valid"}, WIDTH'(rsp_valid), WIDTH'(1));
        chk({tag, ".hold_result"}, rsp_result, e.result);
        chk({tag, ".hold_req_ready"}, WIDTH'(req_ready), WIDTH'(0));
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 chk({tag, ".req_ready_done"}, WIDTH'(req_ready), WIDTH'(0));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".valid_drop"}, WIDTH'(rsp_valid), WIDTH'(0));
    chk({tag, ".back_idle"}, WIDTH'(req_ready), WIDTH'(1));
  endtask

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_ctl = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", WIDTH'(req_ready), WIDTH'(1));
    chk("rst.rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
    chk("rst.result", rsp_result, '0);
    chk("rst.flags", WIDTH'({rsp_zero, rsp_overflow, rsp_illegal}), WIDTH'(0));
    chk("rst.slc", WIDTH'({slc_ctl, slc_a, slc_b, slc_invb, slc_cin}), WIDTH'(0));
    @(negedge clk); rst = 1'b0;

    run_op("add7_5",   FN_ADD, 32'd7,          32'd5,          0);
    run_op("sub_ovf",  FN_SUB, 32'h8000_0000,  32'd1,          0);
    run_op("sub5_5",   FN_SUB, 32'd5,          32'd5,          0);
    run_op("add_ovf",  FN_ADD, 32'h7FFF_FFFF,  32'd1,          0);
    run_op("slt_m1_1", FN_SLT, 32'hFFFF_FFFF,  32'd1,          0);
    run_op("slt_ovf",  FN_SLT, 32'h7FFF_FFFF,  32'h8000_0000,  0);
    run_op("slt3_3",   FN_SLT, 32'd3,          32'd3,          0);
    run_op("and",      FN_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  10);
    run_op("or",       FN_OR,  32'hF0F0_F0F0,  32'hFF00_FF00,  0);

    // Abort mid-RUN at bit 16.
    @(negedge clk);
    req_valid = 1'b1; req_ctl = FN_ADD; req_a = 32'h0001_0000; req_b = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    chk("abort.slc_a_bit16", WIDTH'(slc_a), WIDTH'(1));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("abort.rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
    chk("abort.req_ready", WIDTH'(req_ready), WIDTH'(1));
    chk("abort.result", rsp_result, '0);
    chk("abort.slc_a", WIDTH'(slc_a), WIDTH'(0));
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    chk("abort.no_rsp", WIDTH'(seen), WIDTH'(0));

    run_op("add1_1",   FN_ADD, 32'd1,          32'd1,          0);
    run_op("illegal0", 6'd0,   32'd100,        32'd23,         0);
    run_op("ill_wrap", 6'd63,  32'hFFFF_FFFF,  32'd1,          0);
    for (int i = 0; i < 4; i++) begin
      logic [5:0] fns [5];
      fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      run_op("rand", fns[$urandom_range(0, 4)], $urandom, $urandom, 0);
    end

    chk("sb.drained", WIDTH'(sb.size()), WIDTH'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
